// File: rtl/key_stim_if.sv
// Key-stimulus port bundle: request/hold from the controller, generated key line and status back.
// start is a level request sampled only while busy is low; busy rising is the acknowledge, done closes the press.
interface key_stim_if #(
  parameter int CNT_W = 32
);
  logic             start;
  logic [CNT_W-1:0] hold;
  logic             key;
  logic             busy;
  logic             done;
  logic [2:0]       dbg_state;

  modport master (output start, output hold, input key, input busy, input done, input dbg_state);
  modport slave  (input start, input hold, output key, output busy, output done, output dbg_state);
endinterface

// File: rtl/key_stim.sv
// Bouncy active-low push-button generator: press bounce, stable hold, release bounce, settle, done pulse.
// Bounce half-periods come from a 16-bit Fibonacci LFSR masked by GAP_MASK.
module key_stim #(
  parameter int          CNT_W    = 32,
  parameter int          BOUNCE_N = 4,
  parameter logic [15:0] GAP_MASK = 16'h00FF,
  parameter int          SETTLE   = 500_000,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input logic        clk,
  input logic        rst_n,
  key_stim_if.slave  ks
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PRESS   = 3'd1,
    S_HOLD    = 3'd2,
    S_RELEASE = 3'd3,
    S_SETTLE  = 3'd4,
    S_DONE    = 3'd5
  } state_e;

  localparam int               HALF_W     = (BOUNCE_N > 1) ? $clog2(2 * BOUNCE_N) : 1;
  localparam logic [HALF_W-1:0] LAST_HALF = HALF_W'((BOUNCE_N > 0) ? (2 * BOUNCE_N - 1) : 0);
  localparam logic [CNT_W-1:0]  ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0]  SETTLE_CNT = CNT_W'((SETTLE == 0) ? 1 : SETTLE);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  hold_q, hold_d;
  logic [HALF_W-1:0] half_q, half_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic              key_q, key_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [15:0]       lfsr_next;
  logic [CNT_W-1:0]  interval;

  // Taps x^16+x^14+x^13+x^11+1; the interval uses the value before the step.
  assign lfsr_next = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign interval  = CNT_W'(lfsr_q & GAP_MASK) + ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
      half_q  <= '0;
      lfsr_q  <= SEED;
      key_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      half_q  <= half_d;
      lfsr_q  <= lfsr_d;
      key_q   <= key_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    half_d  = half_q;
    lfsr_d  = lfsr_q;
    case (state_q)
      S_IDLE: begin
        if (ks.start) begin
          hold_d = (ks.hold == '0) ? ONE : ks.hold;
          if (BOUNCE_N > 0) begin
            state_d = S_PRESS;
            half_d  = '0;
            cnt_d   = interval;
            lfsr_d  = lfsr_next;
          end else begin
            state_d = S_HOLD;
            cnt_d   = hold_d;
          end
        end
      end
      S_PRESS: begin
        if (cnt_q == ONE) begin
          if (half_q == LAST_HALF) begin
            state_d = S_HOLD;
            cnt_d   = hold_q;
          end else begin
            half_d = half_q + HALF_W'(1);
            cnt_d  = interval;
            lfsr_d = lfsr_next;
          end
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      S_HOLD: begin
        if (cnt_q == ONE) begin
          if (BOUNCE_N > 0) begin
            state_d = S_RELEASE;
            half_d  = '0;
            cnt_d   = interval;
            lfsr_d  = lfsr_next;
          end else begin
            state_d = S_SETTLE;
            cnt_d   = SETTLE_CNT;
          end
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      S_RELEASE: begin
        if (cnt_q == ONE) begin
          if (half_q == LAST_HALF) begin
            state_d = S_SETTLE;
            cnt_d   = SETTLE_CNT;
          end else begin
            half_d = half_q + HALF_W'(1);
            cnt_d  = interval;
            lfsr_d = lfsr_next;
          end
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      S_SETTLE: begin
        if (cnt_q == ONE) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered key changes on the accepting edge.
  always_comb begin
    key_d  = 1'b1;
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
    case (state_d)
      S_PRESS:   key_d = half_d[0];
      S_HOLD:    key_d = 1'b0;
      S_RELEASE: key_d = ~half_d[0];
      default:   key_d = 1'b1;
    endcase
  end

  assign ks.key       = key_q;
  assign ks.busy      = busy_q;
  assign ks.done      = done_q;
  assign ks.dbg_state = state_q;

endmodule

// File: tb/tb_key_stim.sv
// Bench for key_stim: four parameterisations checked cycle by cycle against a waveform model.
// The model builds each press as a list of {busy,done,key} samples straight from the bounce/hold/settle rules.
module tb_key_stim;

  localparam int          NDUT = 4;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam int          BN_T  [NDUT] = '{2, 0, 1, 4};
  localparam logic [15:0] GAP_T [NDUT] = '{16'h0000, 16'h0000, 16'h0000, 16'h000F};
  localparam int          SET_T [NDUT] = '{5, 1, 2, 3};

  logic        clk;
  logic        rst_n;
  logic        start_v [NDUT];
  logic [31:0] hold_v  [NDUT];
  logic        key_v   [NDUT];
  logic        busy_v  [NDUT];
  logic        done_v  [NDUT];

  key_stim_if #(.CNT_W(32)) ifs [NDUT] ();

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    key_stim #(
      .CNT_W    (32),
      .BOUNCE_N (BN_T[g]),
      .GAP_MASK (GAP_T[g]),
      .SETTLE   (SET_T[g]),
      .SEED     (SEED)
    ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .ks    (ifs[g])
    );
    assign ifs[g].start = start_v[g];
    assign ifs[g].hold  = hold_v[g];
    assign key_v[g]     = ifs[g].key;
    assign busy_v[g]    = ifs[g].busy;
    assign done_v[g]    = ifs[g].done;
  end

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // scoreboard
  int          n_vec;
  int          n_err;
  logic [2:0]  exp_q[$];
  logic [15:0] mdl_lfsr [NDUT];

  function automatic logic [15:0] lfsr_adv(input logic [15:0] s);
    return {s[14:0], ^(s & 16'hB400)};
  endfunction

  function automatic void push_n(input int n, input logic [2:0] v);
    for (int i = 0; i < n; i++) exp_q.push_back(v);
  endfunction

  // One full press: bounce halves around each edge, each a fresh 1+(lfsr&mask) long.
  function automatic void model_press(input int idx, input int hold_in);
    int iv;
    for (int g = 0; g < 2 * BN_T[idx]; g++) begin
      iv = 1 + int'(mdl_lfsr[idx] & GAP_T[idx]);
      mdl_lfsr[idx] = lfsr_adv(mdl_lfsr[idx]);
      push_n(iv, {2'b10, (g % 2 == 1)});
    end
    push_n((hold_in == 0) ? 1 : hold_in, 3'b100);
    for (int g = 0; g < 2 * BN_T[idx]; g++) begin
      iv = 1 + int'(mdl_lfsr[idx] & GAP_T[idx]);
      mdl_lfsr[idx] = lfsr_adv(mdl_lfsr[idx]);
      push_n(iv, {2'b10, (g % 2 == 0)});
    end
    push_n((SET_T[idx] == 0) ? 1 : SET_T[idx], 3'b101);
    push_n(1, 3'b111);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [31:0] obs_of(input int idx);
    return {29'b0, busy_v[idx], done_v[idx], key_v[idx]};
  endfunction

  // driver: mode 0 = single pulse, 1 = random start/hold noise while busy, 2 = start held high
  task automatic run_window(input int idx, input int hold_in, input int mode, input string tag);
    logic [2:0] e;
    int n;
    @(negedge clk);
    start_v[idx] = 1'b1;
    hold_v[idx]  = hold_in;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      chk($sformatf("%s_u%0d_c%0d", tag, idx, i), obs_of(idx), {29'b0, e});
      case (mode)
        0: start_v[idx] = 1'b0;
        1: begin
          start_v[idx] = (i == n - 1) ? 1'b1 : 1'($urandom_range(0, 1));
          hold_v[idx]  = $urandom;
        end
        default: if (i == n - 1) start_v[idx] = 1'b0;
      endcase
    end
    @(negedge clk);
    chk($sformatf("%s_u%0d_idle0", tag, idx), obs_of(idx), 32'h1);
    start_v[idx] = 1'b0;
    @(negedge clk);
    chk($sformatf("%s_u%0d_idle1", tag, idx), obs_of(idx), 32'h1);
  endtask

  task automatic reset_models();
    for (int i = 0; i < NDUT; i++) mdl_lfsr[i] = SEED;
    exp_q.delete();
  endtask

  initial begin
    logic [2:0] e;
    int holds [3];
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    for (int i = 0; i < NDUT; i++) begin
      start_v[i] = 1'b0;
      hold_v[i]  = '0;
    end
    reset_models();
    repeat (3) @(negedge clk);
    for (int i = 0; i < NDUT; i++) chk($sformatf("reset_u%0d", i), obs_of(i), 32'h1);
    rst_n = 1'b1;

    // clean glitches, hold 10: 0,1,0,1, 0x10, 1,0,1,0, 1x5, done
    model_press(0, 10);
    run_window(0, 10, 0, "basic");

    // no bounce, hold 0 promoted to 1
    model_press(1, 0);
    run_window(1, 0, 0, "nobounce");

    // start and hold noise while busy must not change anything
    model_press(0, 7);
    run_window(0, 7, 1, "noise");

    // start held high: three identical windows, one idle cycle between
    model_press(2, 4);
    push_n(1, 3'b001);
    model_press(2, 4);
    push_n(1, 3'b001);
    model_press(2, 4);
    run_window(2, 4, 2, "b2b");

    // random holds on the clean-edge units
    for (int k = 0; k < 4; k++) begin
      holds[0] = $urandom_range(0, 12);
      model_press(k % 3, holds[0]);
      run_window(k % 3, holds[0], 0, "rnd");
    end

    // asynchronous reset during release while key is low
    model_press(0, 3);
    @(negedge clk);
    start_v[0] = 1'b1;
    hold_v[0]  = 3;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      chk($sformatf("rstpre_c%0d", i), obs_of(0), {29'b0, e});
      start_v[0] = 1'b0;
    end
    #1 rst_n = 1'b0;
    #1 chk("rst_async", obs_of(0), 32'h1);
    reset_models();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("rst_idle_c%0d", i), obs_of(0), 32'h1);
    end

    // LFSR-driven bounce, then the same run again after reset
    for (int k = 0; k < 3; k++) holds[k] = $urandom_range(0, 20);
    for (int rep = 0; rep < 2; rep++) begin
      for (int k = 0; k < 3; k++) begin
        model_press(3, holds[k]);
        run_window(3, holds[k], 0, $sformatf("lfsr_r%0d", rep));
      end
      @(negedge clk);
      rst_n = 1'b0;
      reset_models();
      @(negedge clk);
      rst_n = 1'b1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
